// File: rtl/rgb_decoder_if.sv
// rgb_decoder_if: light input and decoded colour bus between a driver and the decoder
interface rgb_decoder_if;
  logic        enable;
  logic [23:0] light;
  logic [2:0]  colour;
  logic        valid;
  logic        invalid_code;
  logic [7:0]  change_count;
  modport master(output enable, light, input colour, valid, invalid_code, change_count);
  modport slave(input enable, light, output colour, valid, invalid_code, change_count);
endinterface

// File: rtl/rgb_decoder.sv
// rgb_decoder: three-stage debounced decoder of a 24-bit RGB word into a 3-bit colour code
module rgb_decoder #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  rgb_decoder_if.slave  bus
);
  localparam logic [3:0] LP_MAX = 4'(STABLE_CNT);

  logic [23:0] r_light_q;
  logic        r_primed;
  logic [2:0]  r_cand_q;
  logic [3:0]  r_cnt;
  logic        r_invalid;
  logic [2:0]  r_colour;
  logic        r_valid;
  logic [7:0]  r_count;
  logic [2:0]  w_cand;
  logic        w_hit;

  // table lookup: every channel byte must be 00 or FF; each FF channel sets its code bit
  always_comb begin
    w_cand = {&r_light_q[23:16], &r_light_q[15:8], &r_light_q[7:0]};
    w_hit  = (w_cand[2] || r_light_q[23:16] == 8'h00) &&
             (w_cand[1] || r_light_q[15:8]  == 8'h00) &&
             (w_cand[0] || r_light_q[7:0]   == 8'h00);
  end

  // stage 1: capture light; primed marks that light_q holds a real sample, not the reset zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_light_q <= '0;
      r_primed  <= 1'b0;
    end else if (bus.enable) begin
      r_light_q <= bus.light;
      r_primed  <= 1'b1;
    end

  // stage 2: count consecutive identical hits, restarting on a miss or a new candidate
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cand_q  <= '0;
      r_cnt     <= '0;
      r_invalid <= 1'b0;
    end else if (bus.enable && r_primed) begin
      r_invalid <= !w_hit;
      if (!w_hit)
        r_cnt <= '0;
      else if (w_cand == r_cand_q && r_cnt != 4'd0)
        r_cnt <= (r_cnt < LP_MAX) ? r_cnt + 4'd1 : r_cnt;
      else begin
        r_cand_q <= w_cand;
        r_cnt    <= 4'd1;
      end
    end

  // stage 3: publish a qualified candidate when it differs from the shown colour
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_colour <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else if (bus.enable && r_cnt == LP_MAX && (!r_valid || r_cand_q != r_colour)) begin
      r_colour <= r_cand_q;
      r_valid  <= 1'b1;
      r_count  <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
    end

  assign bus.colour       = r_colour;
  assign bus.valid        = r_valid;
  assign bus.invalid_code = r_invalid;
  assign bus.change_count = r_count;
endmodule

// File: tb/tb_rgb_decoder.sv
// tb_rgb_decoder: vector table plus hand sequences, checked through an expected-result queue
module tb_rgb_decoder;
  typedef struct {
    logic [2:0] colour;
    logic       valid;
    logic       inv;
    logic [7:0] cc;
  } exp_t;

  typedef struct {
    logic [23:0] light;
    logic        en;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tbl[19];

  rgb_decoder_if bus();
  rgb_decoder_if bus1();

  rgb_decoder #(.STABLE_CNT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  rgb_decoder #(.STABLE_CNT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic exp_t mk(input int c, input int v, input int i, input int cc);
    exp_t e;
    e.colour = 3'(c);
    e.valid  = 1'(v);
    e.inv    = 1'(i);
    e.cc     = 8'(cc);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [23:0] l, input logic en, input exp_t e, input string nm);
    exp_t g;
    bus.light  = l;
    bus.enable = en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({nm, ".colour"}, int'(bus.colour), int'(g.colour));
    chk({nm, ".valid"}, int'(bus.valid), int'(g.valid));
    chk({nm, ".invalid"}, int'(bus.invalid_code), int'(g.inv));
    chk({nm, ".count"}, int'(bus.change_count), int'(g.cc));
  endtask

  task automatic drive(input logic [23:0] l);
    bus.light  = l;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.light   = '0;
    bus1.enable = 1'b0;
    bus1.light  = '0;
    for (int n = 0; n < 5; n++) tbl[n] = '{24'hFF0000, 1'b1, mk(0, 0, 0, 0)};
    tbl[5] = '{24'hFF0000, 1'b1, mk(4, 1, 0, 1)};
    for (int n = 6; n < 9; n++) tbl[n] = '{24'h00FF00, 1'b1, mk(4, 1, 0, 1)};
    for (int n = 9; n < 12; n++) tbl[n] = '{24'hFF0000, 1'b1, mk(4, 1, 0, 1)};
    tbl[12] = '{24'h123456, 1'b1, mk(4, 1, 0, 1)};
    tbl[13] = '{24'h0000FF, 1'b1, mk(4, 1, 1, 1)};
    for (int n = 14; n < 18; n++) tbl[n] = '{24'h0000FF, 1'b1, mk(4, 1, 0, 1)};
    tbl[18] = '{24'h0000FF, 1'b1, mk(1, 1, 0, 2)};

    #1;
    chk("reset.colour", int'(bus.colour), 0);
    chk("reset.valid", int'(bus.valid), 0);
    chk("reset.invalid", int'(bus.invalid_code), 0);
    chk("reset.count", int'(bus.change_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    bus1.light  = 24'hFF00FF;
    bus1.enable = 1'b1;
    @(posedge clk); #1;
    chk("sc1.e1.valid", int'(bus1.valid), 0);
    @(posedge clk); #1;
    chk("sc1.e2.valid", int'(bus1.valid), 0);
    @(posedge clk); #1;
    chk("sc1.e3.colour", int'(bus1.colour), 5);
    chk("sc1.e3.valid", int'(bus1.valid), 1);
    chk("sc1.e3.count", int'(bus1.change_count), 1);
    bus1.light = 24'h123456;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sc1.miss.invalid", int'(bus1.invalid_code), 1);
    chk("sc1.miss.colour", int'(bus1.colour), 5);
    bus1.enable = 1'b0;

    for (int n = 0; n < 19; n++) step(tbl[n].light, tbl[n].en, tbl[n].e, $sformatf("tbl%0d", n));

    step(24'h00FFFF, 1'b1, mk(1, 1, 0, 2), "q1");
    step(24'h00FFFF, 1'b1, mk(1, 1, 0, 2), "q2");
    step(24'h00FFFF, 1'b1, mk(1, 1, 0, 2), "q3");
    for (int n = 0; n < 10; n++) step(24'h000000, 1'b0, mk(1, 1, 0, 2), $sformatf("frozen%0d", n));
    step(24'h00FFFF, 1'b1, mk(1, 1, 0, 2), "resume1");
    step(24'h00FFFF, 1'b1, mk(1, 1, 0, 2), "resume2");
    step(24'h00FFFF, 1'b1, mk(3, 1, 0, 3), "resume3");

    for (int n = 0; n < 4; n++) step(24'h0000FF, 1'b1, mk(3, 1, 0, 3), $sformatf("pre_rst%0d", n));
    #2;
    rst = 1'b0;
    #1;
    chk("arst.colour", int'(bus.colour), 0);
    chk("arst.valid", int'(bus.valid), 0);
    chk("arst.invalid", int'(bus.invalid_code), 0);
    chk("arst.count", int'(bus.change_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 5; n++) step(24'h0000FF, 1'b1, mk(0, 0, 0, 0), $sformatf("post_rst%0d", n));
    step(24'h0000FF, 1'b1, mk(1, 1, 0, 1), "post_rst5");

    for (int k = 0; k < 300; k++) begin
      logic [23:0] w;
      w = (k % 2 == 0) ? 24'h00FF00 : 24'h0000FF;
      for (int j = 0; j < 5; j++) drive(w);
      step(w, 1'b1, mk((k % 2 == 0) ? 2 : 1, 1, 0, (k + 2 > 255) ? 255 : k + 2), $sformatf("sat%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_decoder.md
RGB_DECODER -- requirements
Module: rgb_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical decoded samples required before the output colour changes; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  when 1, sample and advance; when 0, every register holds its value.
REQ-005 light  input  24  RGB light word, {R[7:0],G[7:0],B[7:0]}.
REQ-006 colour  output  3  last stable decoded colour code.
REQ-007 valid  output  1  colour holds a decoded value.
REQ-008 invalid_code  output  1  the last sampled light word is not in the colour table.
REQ-009 change_count  output  8  number of colour output updates since reset.

Function
REQ-010 Colour table, code->word: 0=000000, 1=0000FF, 2=00FF00, 3=00FFFF, 4=FF0000, 5=FF00FF, 6=FFFF00, 7=FFFFFF (hex). Any other word is a miss.
REQ-011 Stage 1: on each enabled edge, light_q SHALL capture light.
REQ-012 Decode: cand and hit SHALL be pure combinational functions of light_q via the REQ-010 table.
REQ-013 Stage 2 (enabled edge), hit=0: cnt<=0, invalid_code<=1.
REQ-014 Stage 2 (enabled edge), hit=1 and cand==cand_q and cnt!=0: cnt<=cnt+1, saturating at STABLE_CNT; invalid_code<=0.
REQ-015 Stage 2 (enabled edge), hit=1 otherwise: cand_q<=cand, cnt<=1, invalid_code<=0.
REQ-016 Stage 3 (enabled edge): if cnt==STABLE_CNT and (valid==0 or cand_q!=colour), then colour<=cand_q, valid<=1, and change_count increments.
REQ-017 Stage 3 (enabled edge), otherwise: colour, valid and change_count hold.
REQ-018 change_count SHALL saturate at 255 and never wrap.
REQ-019 Latency: a constant table word present from before edge 1 SHALL appear on colour, with valid=1, after edge STABLE_CNT+2 (edge 6 at default).
REQ-020 A miss, or a different word, arriving before cnt reaches STABLE_CNT SHALL restart qualification; colour SHALL NOT change.
REQ-021 Misses SHALL NOT alter colour, valid or change_count; the last good colour is held.
REQ-022 Once set, valid SHALL remain 1 until reset.
REQ-023 A stable word equal to the current colour SHALL NOT increment change_count.
REQ-024 enable deasserted mid-qualification SHALL freeze cnt.
REQ-025 After enable re-asserts, qualification SHALL resume from the frozen cnt without loss.
REQ-026 With STABLE_CNT=1, a single hit sample qualifies; latency is 3 edges.

Reset
REQ-027 rst=0 SHALL immediately force, independent of clk: light_q=0, cand_q=0, cnt=0, colour=0, valid=0, invalid_code=0, change_count=0.
REQ-028 Reset asserted mid-qualification SHALL discard all progress; after release, qualification restarts from cnt=0.
REQ-029 The first enabled edge after reset release SHALL only load light_q.

Verification
REQ-030 Reset release; enable=1; light=FF0000 held -> colour=4, valid=1 after edge 6; change_count=1.
REQ-031 From colour=4: light=00FF00 for 3 edges, then FF0000 -> colour stays 4; change_count stays 1.
REQ-032 light=123456 for 1 edge -> invalid_code=1 after edge 2; colour and valid unchanged; then 0000FF held -> invalid_code=0, colour=1 after 5 more edges.
REQ-033 Qualifying 00FFFF with enable=0 for 10 cycles after cnt=2 -> outputs frozen; after re-enable, colour=3 exactly 3 enabled edges later.
REQ-034 Alternate two table colours, each held 6 edges, for 300 changes -> change_count stops at 255.
REQ-035 rst=0 asynchronously while cnt=3 -> all outputs 0 before the next edge; after release, full 6-edge latency observed.
